// File: rtl/ddr_aw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ddr_aw_scheduler
// Purpose  : Round-robin arbiter that shares the DDR write-address path among
//            NUM_CH video write channels. A granted channel receives the DDR
//            byte address (channel base + running frame offset), which is
//            pushed into an external address FIFO. A small pop-side FSM drains
//            that FIFO onto the AXI AW channel with a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, tb_rst            clock, asynchronous active-high reset
//   ch_req/ch_ack          per-channel burst request (level) / grant pulse
//   ch_frame_sync          per-channel pulse, restarts the frame offset at 0
//   ch_frame_done          per-channel pulse when the frame offset wraps
//   cfg_base               per-channel frame base, channel i at [i*ADDR_W +: ADDR_W]
//   cfg_frame_bytes        frame size in bytes (multiple of the burst size)
//   fifo_wr_*              address FIFO push interface (+ almost_full)
//   fifo_rd_*              address FIFO pop interface (data 1 cycle after rd_en)
//   m_aw*                  AXI write-address channel master
// Optional feature macro: DDR_AW_SCHED_STATS_EN
//   adds stat_burst_cnt (AW handshakes, wraps) and stat_stall_cnt (cycles with
//   a request blocked by almost_full, saturates).
// ============================================================================
module ddr_aw_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 32,
    parameter int AWLEN      = 15,
    parameter int BEAT_BYTES = 32
) (
    input  logic                     clk,
    input  logic                     tb_rst,
    input  logic [NUM_CH-1:0]        ch_req,
    output logic [NUM_CH-1:0]        ch_ack,
    input  logic [NUM_CH-1:0]        ch_frame_sync,
    output logic [NUM_CH-1:0]        ch_frame_done,
    input  logic [NUM_CH*ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0]        cfg_frame_bytes,
    output logic [ADDR_W-1:0]        fifo_wr_data,
    output logic                     fifo_wr_en,
    input  logic                     fifo_almost_full,
    output logic                     fifo_rd_en,
    input  logic [ADDR_W-1:0]        fifo_rd_data,
    input  logic                     fifo_rd_empty,
    output logic [ADDR_W-1:0]        m_awaddr,
    output logic [7:0]               m_awlen,
    output logic                     m_awvalid,
    input  logic                     m_awready
`ifdef DDR_AW_SCHED_STATS_EN
    ,
    output logic [31:0]              stat_burst_cnt,
    output logic [15:0]              stat_stall_cnt
`endif
);

    localparam int                BURST_BYTES = (AWLEN + 1) * BEAT_BYTES;
    localparam logic [ADDR_W-1:0] C_BURST_INC = ADDR_W'(BURST_BYTES);
    localparam int                PTR_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W:0]    C_NUM_CH    = (PTR_W + 1)'(NUM_CH);
    localparam logic [PTR_W-1:0]  C_LAST_CH   = PTR_W'(NUM_CH - 1);

    // ------------------------------------------------------------------------
    // Push side: arbitration and address generation
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_base   [NUM_CH];
    logic [ADDR_W-1:0] r_offset [NUM_CH];
    logic [NUM_CH-1:0] w_elig;
    logic              w_gnt_vld;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0] w_gnt_off;
    logic [ADDR_W-1:0] w_off_inc;
    logic              w_wrap;
    logic [NUM_CH-1:0] r_ack;
    logic [NUM_CH-1:0] r_frame_done;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_data;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_base
            assign w_base[gi] = cfg_base[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // A channel acked this cycle is still showing its old request level; it
    // must not win again before the requester has had a chance to drop it.
    assign w_elig = ch_req & ~ch_frame_sync & ~r_ack & {NUM_CH{~fifo_almost_full}};

    // Rotating priority: search from r_rr_ptr upward. The loop runs from the
    // farthest candidate to the nearest so the nearest eligible one wins.
    always_comb begin
        logic [PTR_W:0] idx;
        idx       = '0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
            if (idx >= C_NUM_CH) begin
                idx = idx - C_NUM_CH;
            end
            if (w_elig[idx[PTR_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = idx[PTR_W-1:0];
            end
        end
    end

    assign w_gnt_off = r_offset[w_gnt_idx];
    assign w_off_inc = w_gnt_off + C_BURST_INC;
    assign w_wrap    = (w_off_inc >= cfg_frame_bytes);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_ack        <= '0;
            r_frame_done <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_rr_ptr     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_offset[i] <= '0;
            end
        end else begin
            r_ack        <= '0;
            r_frame_done <= '0;
            r_wr_en      <= w_gnt_vld;
            // A syncing channel is never granted in the same cycle, so these
            // clears cannot collide with the offset update below.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_frame_sync[i]) begin
                    r_offset[i] <= '0;
                end
            end
            if (w_gnt_vld) begin
                r_ack[w_gnt_idx]        <= 1'b1;
                r_frame_done[w_gnt_idx] <= w_wrap;
                r_wr_data               <= w_base[w_gnt_idx] + w_gnt_off;
                r_offset[w_gnt_idx]     <= w_wrap ? '0 : w_off_inc;
                r_rr_ptr                <= (w_gnt_idx == C_LAST_CH) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign ch_ack        = r_ack;
    assign ch_frame_done = r_frame_done;
    assign fifo_wr_en    = r_wr_en;
    assign fifo_wr_data  = r_wr_data;

    // ------------------------------------------------------------------------
    // Pop side: FIFO -> AXI AW
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } pop_state_t;

    pop_state_t        r_state;
    pop_state_t        w_state_nxt;
    logic              w_rd_en;
    logic              w_load;
    logic              w_clear;
    logic [ADDR_W-1:0] r_awaddr;
    logic              r_awvalid;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The FIFO has no output register: data popped in one cycle is on
    // fifo_rd_data in the next, which is the FETCH state.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!fifo_rd_empty) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_load      = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (m_awready) begin
                    w_clear = 1'b1;
                    if (!fifo_rd_empty) begin
                        w_rd_en     = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
        end else begin
            if (w_load) begin
                r_awaddr  <= fifo_rd_data;
                r_awvalid <= 1'b1;
            end else if (w_clear) begin
                r_awvalid <= 1'b0;
            end
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_awaddr   = r_awaddr;
    assign m_awvalid  = r_awvalid;
    assign m_awlen    = 8'(AWLEN);

`ifdef DDR_AW_SCHED_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
    logic [31:0] r_burst_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_burst_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_awvalid && m_awready) begin
                r_burst_cnt <= r_burst_cnt + 32'd1;
            end
            if ((|ch_req) && fifo_almost_full && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stat_burst_cnt = r_burst_cnt;
    assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr_aw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_aw_scheduler
// Purpose  : Self-checking bench for ddr_aw_scheduler with a behavioural
//            address FIFO and a reference model of grants and AW ordering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_aw_scheduler;

    localparam int NUM_CH   = 4;
    localparam int BURST    = 512;
    localparam int AF_LEVEL = 500;

    logic        clk = 1'b0;
    logic        tb_rst;
    logic [3:0]  ch_req, ch_frame_sync, ch_ack, ch_frame_done;
    logic [31:0] base [NUM_CH];
    logic [127:0] cfg_base;
    logic [31:0] cfg_frame_bytes;
    logic [31:0] fifo_wr_data, fifo_rd_data, m_awaddr;
    logic        fifo_wr_en, fifo_almost_full, fifo_rd_en, fifo_rd_empty;
    logic [7:0]  m_awlen;
    logic        m_awvalid, m_awready;
    logic        af_force;
`ifdef DDR_AW_SCHED_STATS_EN
    logic [31:0] stat_burst_cnt;
    logic [15:0] stat_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign cfg_base = {base[3], base[2], base[1], base[0]};

    ddr_aw_scheduler dut (
        .clk              (clk),
        .tb_rst           (tb_rst),
        .ch_req           (ch_req),
        .ch_ack           (ch_ack),
        .ch_frame_sync    (ch_frame_sync),
        .ch_frame_done    (ch_frame_done),
        .cfg_base         (cfg_base),
        .cfg_frame_bytes  (cfg_frame_bytes),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_almost_full (fifo_almost_full),
        .fifo_rd_en       (fifo_rd_en),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_rd_empty    (fifo_rd_empty),
        .m_awaddr         (m_awaddr),
        .m_awlen          (m_awlen),
        .m_awvalid        (m_awvalid),
        .m_awready        (m_awready)
`ifdef DDR_AW_SCHED_STATS_EN
        ,
        .stat_burst_cnt   (stat_burst_cnt),
        .stat_stall_cnt   (stat_stall_cnt)
`endif
    );

    // ---------------- behavioural 32 x 512 FIFO, no output register --------
    logic [31:0] fmem [512];
    logic [9:0]  wr_ptr, rd_ptr, fifo_count;

    always @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_rd_data <= '0;
        end else begin
            if (fifo_wr_en) begin
                fmem[wr_ptr[8:0]] <= fifo_wr_data;
                wr_ptr            <= wr_ptr + 10'd1;
            end
            if (fifo_rd_en) begin
                fifo_rd_data <= fmem[rd_ptr[8:0]];
                rd_ptr       <= rd_ptr + 10'd1;
            end
        end
    end

    assign fifo_count       = wr_ptr - rd_ptr;
    assign fifo_rd_empty    = (fifo_count == 10'd0);
    assign fifo_almost_full = af_force | (fifo_count >= 10'(AF_LEVEL));

    // ---------------- reference model --------------------------------------
    // Grants: first eligible channel after the last granted one (mod 4).
    logic [3:0]  m_ack, m_done;
    logic        m_wr_en;
    logic [31:0] m_wr_data;
    logic [31:0] m_off [NUM_CH];
    logic [1:0]  m_last, m_gnt;
    logic        m_gnt_vld;
    logic [31:0] sb [$];
    logic        hs_seen;
    logic [31:0] hs_act, hs_exp;
    int          hs_total;

    always_comb begin
        logic [1:0] c;
        c         = '0;
        m_gnt_vld = 1'b0;
        m_gnt     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = m_last + 2'(k);
            if (!m_gnt_vld && !fifo_almost_full && ch_req[c] && !ch_frame_sync[c] && !m_ack[c]) begin
                m_gnt_vld = 1'b1;
                m_gnt     = c;
            end
        end
    end

    always @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            m_ack     <= '0;
            m_done    <= '0;
            m_wr_en   <= 1'b0;
            m_wr_data <= '0;
            m_last    <= 2'd3;
            hs_seen   <= 1'b0;
            hs_total  <= 0;
            for (int i = 0; i < NUM_CH; i++) m_off[i] <= '0;
            sb.delete();
        end else begin
            m_ack   <= '0;
            m_done  <= '0;
            m_wr_en <= m_gnt_vld;
            for (int i = 0; i < NUM_CH; i++) if (ch_frame_sync[i]) m_off[i] <= '0;
            if (m_gnt_vld) begin
                m_ack[m_gnt] <= 1'b1;
                m_wr_data    <= base[m_gnt] + m_off[m_gnt];
                sb.push_back(base[m_gnt] + m_off[m_gnt]);
                if (m_off[m_gnt] + 32'(BURST) >= cfg_frame_bytes) begin
                    m_off[m_gnt]  <= '0;
                    m_done[m_gnt] <= 1'b1;
                end else begin
                    m_off[m_gnt] <= m_off[m_gnt] + 32'(BURST);
                end
                m_last <= m_gnt;
            end
            hs_seen <= m_awvalid && m_awready;
            if (m_awvalid && m_awready) begin
                hs_act   <= m_awaddr;
                hs_exp   <= (sb.size() > 0) ? sb.pop_front() : ~m_awaddr;
                hs_total <= hs_total + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        tb_rst = 1'b1;
        tick();
        tick();
        checks++; if (ch_ack !== 4'd0) begin failures++; $display("FAIL reset_ack actual=%b required=0", ch_ack); end
        checks++; if (ch_frame_done !== 4'd0) begin failures++; $display("FAIL reset_done actual=%b required=0", ch_frame_done); end
        checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en actual=%b required=0", fifo_wr_en); end
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en actual=%b required=0", fifo_rd_en); end
        checks++; if (m_awvalid !== 1'b0) begin failures++; $display("FAIL reset_awvalid actual=%b required=0", m_awvalid); end
        checks++; if (fifo_wr_data !== 32'd0) begin failures++; $display("FAIL reset_wr_data actual=%h required=0", fifo_wr_data); end
        checks++; if (m_awaddr !== 32'd0) begin failures++; $display("FAIL reset_awaddr actual=%h required=0", m_awaddr); end
        checks++; if (m_awlen !== 8'd15) begin failures++; $display("FAIL awlen actual=%0d required=15", m_awlen); end
        tb_rst = 1'b0;
    endtask

    task automatic test_drain(input string tag);
        int cyc;
        ch_req    = '0;
        m_awready = 1'b1;
        af_force  = 1'b0;
        cyc       = 0;
        while ((sb.size() != 0 || m_awvalid || !fifo_rd_empty) && cyc < 2000) begin
            tick();
            cyc++;
            if (hs_seen) begin
                checks++;
                if (hs_act !== hs_exp) begin failures++; $display("FAIL %s_drain_aw actual=%h required=%h", tag, hs_act, hs_exp); end
            end
        end
        checks++;
        if (sb.size() != 0 || m_awvalid) begin
            failures++;
            $display("FAIL %s_drain_timeout actual_pending=%0d required_pending=0", tag, sb.size());
        end
    endtask

    task automatic test_single_channel();
        logic [31:0] want [5];
        logic [31:0] got [$];
        int          nacks;
        want = '{32'h1000_0000, 32'h1000_0200, 32'h1000_0400, 32'h1000_0600, 32'h1000_0000};
        nacks = 0;
        base[0] = 32'h1000_0000;
        cfg_frame_bytes = 32'd2048;
        m_awready = 1'b1;
        ch_req = 4'b0001;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            checks++;
            if (ch_ack !== m_ack || ch_frame_done !== m_done || fifo_wr_en !== m_wr_en) begin
                failures++;
                $display("FAIL single_push actual ack=%b done=%b wr=%b required ack=%b done=%b wr=%b",
                         ch_ack, ch_frame_done, fifo_wr_en, m_ack, m_done, m_wr_en);
            end
            if (m_wr_en) begin
                checks++;
                if (fifo_wr_data !== m_wr_data) begin failures++; $display("FAIL single_wr_data actual=%h required=%h", fifo_wr_data, m_wr_data); end
            end
            if (ch_ack[0]) begin
                nacks++;
                checks++;
                if (ch_frame_done[0] !== (nacks % 4 == 0)) begin
                    failures++;
                    $display("FAIL single_frame_done ack#%0d actual=%b required=%b", nacks, ch_frame_done[0], (nacks % 4 == 0));
                end
            end
            if (hs_seen) begin
                got.push_back(hs_act);
                checks++;
                if (hs_act !== hs_exp) begin failures++; $display("FAIL single_aw actual=%h required=%h", hs_act, hs_exp); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== want[i]) begin
                failures++;
                $display("FAIL single_aw_seq idx=%0d actual=%h required=%h", i, (got.size() > i) ? got[i] : 32'hx, want[i]);
            end
        end
        test_drain("single");
    endtask

    task automatic test_all_channels();
        logic [31:0] last_addr [NUM_CH];
        logic [3:0]  seen;
        int          prev;
        base[0] = 32'h0000_0000; base[1] = 32'h0010_0000;
        base[2] = 32'h0020_0000; base[3] = 32'h0030_0000;
        cfg_frame_bytes = 32'h0001_0000;
        seen = '0;
        prev = -1;
        ch_req = 4'hF;
        for (int cyc = 0; cyc < 24; cyc++) begin
            tick();
            checks++;
            if (ch_ack !== m_ack || fifo_wr_en !== m_wr_en || fifo_wr_data !== m_wr_data) begin
                failures++;
                $display("FAIL all_push actual ack=%b wr=%b data=%h required ack=%b wr=%b data=%h",
                         ch_ack, fifo_wr_en, fifo_wr_data, m_ack, m_wr_en, m_wr_data);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_ack[i]) begin
                    if (prev >= 0) begin
                        checks++;
                        if (i != (prev + 1) % NUM_CH) begin failures++; $display("FAIL all_rr_order actual=%0d required=%0d", i, (prev + 1) % NUM_CH); end
                    end
                    if (seen[i]) begin
                        checks++;
                        if (fifo_wr_data !== last_addr[i] + 32'(BURST)) begin
                            failures++;
                            $display("FAIL all_addr_step ch=%0d actual=%h required=%h", i, fifo_wr_data, last_addr[i] + 32'(BURST));
                        end
                    end
                    seen[i] = 1'b1;
                    last_addr[i] = fifo_wr_data;
                    prev = i;
                end
            end
            if (cyc > 0) begin
                checks++;
                if ($countones(ch_ack) != 1) begin failures++; $display("FAIL all_one_per_cycle actual=%b required=onehot", ch_ack); end
            end
            if (hs_seen) begin
                checks++;
                if (hs_act !== hs_exp) begin failures++; $display("FAIL all_aw actual=%h required=%h", hs_act, hs_exp); end
            end
        end
        test_drain("all");
    endtask

    task automatic test_almost_full();
        ch_req   = 4'hF;
        af_force = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            checks++;
            if (ch_ack !== 4'd0 || fifo_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL af_blocked actual ack=%b wr=%b required ack=0 wr=0", ch_ack, fifo_wr_en);
            end
        end
        af_force = 1'b0;
        tick();
        checks++;
        if (fifo_wr_en !== 1'b1 || ch_ack !== m_ack) begin
            failures++;
            $display("FAIL af_resume actual wr=%b ack=%b required wr=1 ack=%b", fifo_wr_en, ch_ack, m_ack);
        end
`ifdef DDR_AW_SCHED_STATS_EN
        checks++;
        if (stat_stall_cnt !== 16'd20) begin failures++; $display("FAIL stat_stall actual=%0d required=20", stat_stall_cnt); end
`endif
        test_drain("af");
`ifdef DDR_AW_SCHED_STATS_EN
        checks++;
        if (stat_burst_cnt !== 32'(hs_total)) begin failures++; $display("FAIL stat_burst actual=%0d required=%0d", stat_burst_cnt, hs_total); end
`endif
    endtask

    task automatic test_awready_stall();
        logic [31:0] held;
        int          cyc;
        m_awready = 1'b0;
        ch_req    = 4'hF;
        cyc       = 0;
        while (!m_awvalid && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (m_awvalid !== 1'b1) begin failures++; $display("FAIL stall_wait_valid actual=%b required=1", m_awvalid); end
        held = m_awaddr;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (m_awvalid !== 1'b1 || m_awaddr !== held || fifo_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold actual valid=%b addr=%h rd=%b required valid=1 addr=%h rd=0",
                         m_awvalid, m_awaddr, fifo_rd_en, held);
            end
        end
        ch_req    = 4'h0;
        m_awready = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL stall_release_rd actual=%b required=1", fifo_rd_en); end
        tick();
        checks++;
        if (hs_seen !== 1'b1 || hs_act !== held || hs_exp !== held || m_awvalid !== 1'b0) begin
            failures++;
            $display("FAIL stall_handshake actual hs=%b addr=%h valid=%b required hs=1 addr=%h valid=0",
                     hs_seen, hs_act, m_awvalid, held);
        end
        tick();
        checks++;
        if (m_awvalid !== 1'b1 || sb.size() == 0 || m_awaddr !== sb[0]) begin
            failures++;
            $display("FAIL stall_next_addr actual valid=%b addr=%h required valid=1 addr=%h",
                     m_awvalid, m_awaddr, (sb.size() > 0) ? sb[0] : 32'hx);
        end
        test_drain("stall");
    endtask

    task automatic test_frame_sync();
        int cyc;
        base[1] = 32'h4567_0000;
        cfg_frame_bytes = 32'h0001_0000;
        m_awready = 1'b1;
        ch_req = 4'b0010;
        cyc = 0;
        while (!ch_ack[1] && cyc < 10) begin
            tick();
            cyc++;
        end
        checks++;
        if (ch_ack[1] !== 1'b1) begin failures++; $display("FAIL sync_first_ack actual=%b required=1", ch_ack[1]); end
        ch_req = 4'b0000;
        tick();
        ch_req        = 4'b0010;
        ch_frame_sync = 4'b0010;
        tick();
        checks++;
        if (ch_ack[1] !== 1'b0 || fifo_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL sync_no_grant actual ack=%b wr=%b required ack=0 wr=0", ch_ack[1], fifo_wr_en);
        end
        ch_frame_sync = 4'b0000;
        tick();
        checks++;
        if (ch_ack[1] !== 1'b1 || fifo_wr_data !== base[1]) begin
            failures++;
            $display("FAIL sync_restart actual ack=%b data=%h required ack=1 data=%h", ch_ack[1], fifo_wr_data, base[1]);
        end
        test_drain("sync");
    endtask

    task automatic test_random();
        for (int i = 0; i < NUM_CH; i++) base[i] = $urandom;
        cfg_frame_bytes = 32'(BURST * $urandom_range(1, 6));
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_ack[i]) ch_req[i] = ($urandom_range(0, 3) == 0);
                else if (!ch_req[i]) ch_req[i] = ($urandom_range(0, 2) == 0);
                ch_frame_sync[i] = ($urandom_range(0, 39) == 0);
            end
            af_force  = ($urandom_range(0, 7) == 0);
            m_awready = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (ch_ack !== m_ack || ch_frame_done !== m_done || fifo_wr_en !== m_wr_en) begin
                failures++;
                $display("FAIL rand_push cyc=%0d actual ack=%b done=%b wr=%b required ack=%b done=%b wr=%b",
                         cyc, ch_ack, ch_frame_done, fifo_wr_en, m_ack, m_done, m_wr_en);
            end
            if (m_wr_en) begin
                checks++;
                if (fifo_wr_data !== m_wr_data) begin failures++; $display("FAIL rand_wr_data actual=%h required=%h", fifo_wr_data, m_wr_data); end
            end
            if (hs_seen) begin
                checks++;
                if (hs_act !== hs_exp) begin failures++; $display("FAIL rand_aw actual=%h required=%h", hs_act, hs_exp); end
            end
        end
        ch_frame_sync = '0;
        test_drain("rand");
    endtask

    task automatic test_reset_mid();
        logic [3:0] seen;
        int         cyc;
        base[0] = 32'h8000_0000; base[1] = 32'h8100_0000;
        base[2] = 32'h8200_0000; base[3] = 32'h8300_0000;
        cfg_frame_bytes = 32'h0001_0000;
        m_awready = 1'b0;
        ch_req = 4'hF;
        cyc = 0;
        while ((!m_awvalid || cyc < 8) && cyc < 30) begin
            tick();
            cyc++;
        end
        tb_rst = 1'b1;
        #1;
        checks++;
        if (ch_ack !== 4'd0 || ch_frame_done !== 4'd0 || fifo_wr_en !== 1'b0 || fifo_rd_en !== 1'b0 ||
            m_awvalid !== 1'b0 || fifo_wr_data !== 32'd0 || m_awaddr !== 32'd0) begin
            failures++;
            $display("FAIL midreset_outputs actual ack=%b done=%b wr=%b rd=%b valid=%b data=%h addr=%h required all 0",
                     ch_ack, ch_frame_done, fifo_wr_en, fifo_rd_en, m_awvalid, fifo_wr_data, m_awaddr);
        end
        tick();
        tick();
        tb_rst = 1'b0;
        m_awready = 1'b1;
        seen = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (ch_ack !== m_ack || fifo_wr_en !== m_wr_en) begin
                failures++;
                $display("FAIL midreset_push actual ack=%b wr=%b required ack=%b wr=%b", ch_ack, fifo_wr_en, m_ack, m_wr_en);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_ack[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    checks++;
                    if (fifo_wr_data !== base[i]) begin failures++; $display("FAIL midreset_first_addr ch=%0d actual=%h required=%h", i, fifo_wr_data, base[i]); end
                end
            end
            if (hs_seen) begin
                checks++;
                if (hs_act !== hs_exp) begin failures++; $display("FAIL midreset_aw actual=%h required=%h", hs_act, hs_exp); end
            end
        end
        checks++;
        if (seen !== 4'hF) begin failures++; $display("FAIL midreset_all_granted actual=%b required=1111", seen); end
        test_drain("midreset");
    endtask

    initial begin
        tb_rst          = 1'b0;
        ch_req          = '0;
        ch_frame_sync   = '0;
        cfg_frame_bytes = 32'd2048;
        m_awready       = 1'b0;
        af_force        = 1'b0;
        for (int i = 0; i < NUM_CH; i++) base[i] = '0;
        #2;
        test_reset();
        test_single_channel();
        test_all_channels();
        test_almost_full();
        test_awready_stall();
        test_frame_sync();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/ddr_aw_scheduler.md
Name: ddr_aw_scheduler

Overview:
- Round-robin scheduler that shares the DDR write-address path among NUM_CH video write channels.
- Each granted burst request gets a DDR byte address (channel base + running frame offset), which is pushed into the 32-bit x 512 awaddr_ddr_fifo.
- The block pops that FIFO and drives the AXI AW channel with a valid/ready handshake.
- It sits between the per-channel frame writers and the DDR controller AXI slave port.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- ADDR_W, 32, address width; equals the FIFO data width.
- AWLEN, 15, fixed AXI burst length minus one.
- BEAT_BYTES, 32, bytes per AXI beat.
- BURST_BYTES, (AWLEN+1)*BEAT_BYTES, derived; offset increment per burst (512 by default).

Ports:
- clk  in  1  system clock; all logic is on this clock.
- tb_rst  in  1  asynchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel burst request; level, held until ch_ack.
- ch_ack  out  NUM_CH  one-cycle grant pulse; the address was pushed this cycle.
- ch_frame_sync  in  NUM_CH  one-cycle pulse; resets that channel's offset to 0.
- ch_frame_done  out  NUM_CH  one-cycle pulse when the channel's offset wraps.
- cfg_base  in  NUM_CH*ADDR_W  per-channel frame base address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- cfg_frame_bytes  in  ADDR_W  frame size in bytes; a multiple of BURST_BYTES, nonzero.
- fifo_wr_data  out  ADDR_W  address written to the FIFO.
- fifo_wr_en  out  1  FIFO push.
- fifo_almost_full  in  1  FIFO almost_full.
- fifo_rd_en  out  1  FIFO pop.
- fifo_rd_data  in  ADDR_W  FIFO read data; valid 1 cycle after fifo_rd_en (no output register).
- fifo_rd_empty  in  1  FIFO empty.
- m_awaddr  out  ADDR_W  AXI AW address.
- m_awlen  out  8  constant AWLEN.
- m_awvalid  out  1  AXI AW valid.
- m_awready  in  1  AXI AW ready.

Behaviour:
- Reset values:
  - ch_ack, ch_frame_done, fifo_wr_en, fifo_rd_en and m_awvalid are 0.
  - fifo_wr_data and m_awaddr are 0.
  - All channel offsets are 0.
  - The round-robin pointer is 0, so channel 0 has highest priority after reset.
- Eligibility: channel i is eligible when ch_req[i]=1, ch_frame_sync[i]=0 and ch_ack[i]=0 in the current cycle. Excluding acked channels prevents a double grant on the cycle the requester is dropping ch_req.
- Push side (one grant per cycle at most):
  - Grants occur only when fifo_almost_full=0.
  - Round-robin search starts at the channel after the last granted one.
  - In the grant cycle, on the next edge: fifo_wr_en=1, fifo_wr_data=cfg_base[i]+offset[i] (mod 2^ADDR_W), ch_ack[i]=1. Request-to-push latency is 1 cycle.
  - Offset update: offset[i] becomes offset[i]+BURST_BYTES. If the new value >= cfg_frame_bytes, offset[i] becomes 0 and ch_frame_done[i] pulses together with ch_ack[i].
- ch_frame_sync[i]:
  - Forces offset[i]=0 on the next edge.
  - Channel i is not granted in that cycle; other channels are unaffected.
- almost_full asserted: no grants and requests stay pending. Pushes issued in the same edge are not retracted.
- Pop side FSM, three states:
  - IDLE: if fifo_rd_empty=0, assert fifo_rd_en for 1 cycle and go to FETCH.
  - FETCH: capture fifo_rd_data into m_awaddr, set m_awvalid=1, go to HOLD.
  - HOLD: m_awaddr is stable while m_awvalid=1. On m_awready=1:
    - if fifo_rd_empty=0, issue fifo_rd_en in the same cycle, clear m_awvalid and go to FETCH;
    - otherwise clear m_awvalid and go to IDLE.
  - This yields one AW every 2 cycles at most.
- Ordering: AW addresses leave in exactly FIFO push order; none are dropped or duplicated.
- m_awlen is tied to AWLEN at all times.
- Reset mid-burst: everything returns to the reset values above. The FIFO is reset by the same tb_rst, so its contents are discarded.

Optional Feature:
- Macro: DDR_AW_SCHED_STATS_EN.
- When defined, two extra outputs are added:
  - stat_burst_cnt [31:0]: increments on each AW handshake (m_awvalid & m_awready); wraps.
  - stat_stall_cnt [15:0]: increments each cycle any ch_req=1 while fifo_almost_full=1; saturates at 16'hFFFF.
- Both counters reset to 0 on tb_rst.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single channel: ch_req[0] held, cfg_base[0]=32'h1000_0000, cfg_frame_bytes=2048, m_awready=1 -> awaddr sequence 1000_0000, 1000_0200, 1000_0400, 1000_0600, then 1000_0000; ch_frame_done[0] pulses with the 4th ack.
- All 4 channels requesting continuously, bases 0x0/0x100000/0x200000/0x300000 -> grants 0,1,2,3,0,... one per cycle; each channel's awaddr increments by 512.
- fifo_almost_full forced high for 20 cycles while requests are held -> no fifo_wr_en and no ch_ack; grants resume the cycle after release. With the macro, stat_stall_cnt=20.
- m_awready held low 10 cycles with the FIFO non-empty -> m_awvalid stays 1 with stable m_awaddr and no extra fifo_rd_en; on ready, the next address appears 2 cycles later.
- ch_frame_sync[1] asserted mid-frame on the same cycle as ch_req[1] -> no ack that cycle; the next ack for channel 1 carries cfg_base[1]+0.
- tb_rst asserted while m_awvalid=1 and offsets are nonzero -> all outputs are 0 immediately; after release, the first address per channel is its cfg_base.
